// File: rtl/matmul_seq_ctrl.sv
// Sequencer that computes a d1 x d3 matrix product on one shared dot-product engine.
// It walks the output elements in row-major order, starts the engine, and writes each result over a ready/valid port.
module matmul_seq_ctrl #(
    parameter int N  = 32,
    parameter int d1 = 5,
    parameter int d3 = 5,
    parameter int RW = (d1 > 1) ? $clog2(d1) : 1,
    parameter int CW = (d3 > 1) ? $clog2(d3) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic          dp_start,
    input  logic          dp_done,
    input  logic [N-1:0]  dp_result,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic [N-1:0]  wr_data
);
    localparam logic [RW-1:0] ROW_LAST = RW'(d1 - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(d3 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [RW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic          armed_reg, armed_next;
    logic [N-1:0]  data_reg, data_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            armed_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            armed_reg <= armed_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        armed_next = armed_reg;
        data_next  = data_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    row_next   = '0;
                    col_next   = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                armed_next = 1'b0;
                state_next = WAIT;
            end
            WAIT: begin
                // A stale done left high by the previous operation only counts after a low sample.
                if (!dp_done) begin
                    armed_next = 1'b1;
                end
                if (armed_reg && dp_done) begin
                    data_next  = dp_result;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (row_reg == ROW_LAST && col_reg == COL_LAST) begin
                        state_next = DONE;
                    end else begin
                        state_next = ISSUE;
                        if (col_reg == COL_LAST) begin
                            col_next = '0;
                            row_next = row_reg + 1'b1;
                        end else begin
                            col_next = col_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next = IDLE;
            row_next   = '0;
            col_next   = '0;
            armed_next = 1'b0;
        end
    end

    // Outputs decode straight from the state register so an async reset clears them at once.
    assign busy     = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == WRITE);
    assign done     = (state_reg == DONE);
    assign dp_start = (state_reg == ISSUE);
    assign wr_valid = (state_reg == WRITE);
    assign row_idx  = row_reg;
    assign col_idx  = col_reg;
    assign wr_row   = row_reg;
    assign wr_col   = col_reg;
    assign wr_data  = data_reg;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl at d1=2, d3=3 with a latency-4 engine model returning 16*row+col.
`timescale 1ns/1ps
module tb_matmul_seq_ctrl;
    localparam int N   = 32;
    localparam int D1  = 2;
    localparam int D3  = 3;
    localparam int RW  = 1;
    localparam int CW  = 2;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, dp_start, wr_valid;
    logic          dp_done = 1'b0;
    logic [N-1:0]  dp_result = '0;
    logic          wr_ready = 1'b1;
    logic [RW-1:0] row_idx, wr_row;
    logic [CW-1:0] col_idx, wr_col;
    logic [N-1:0]  wr_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.N(N), .d1(D1), .d3(D3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .row_idx(row_idx), .col_idx(col_idx),
        .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data)
    );

    // Engine model: hold_mode leaves dp_done high from the last op, dropping it for a single cycle before the new result.
    bit           hold_mode = 1'b0;
    int           eng_cnt = 0;
    logic [N-1:0] eng_res = '0;
    always @(posedge clk) begin
        if (dp_start) begin
            eng_cnt <= LAT;
            eng_res <= N'(16 * row_idx + col_idx);
            if (!hold_mode) dp_done <= 1'b0;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 2 && hold_mode) dp_done <= 1'b0;
            if (eng_cnt == 1) begin
                dp_done   <= 1'b1;
                dp_result <= eng_res;
            end
        end
    end

    int           cyc = 0, wr_cnt = 0, dps_cnt = 0, last_wr_cyc = 0;
    int           log_row [128];
    int           log_col [128];
    logic [N-1:0] log_data [128];
    bit           overlap = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_start) dps_cnt <= dps_cnt + 1;
        if (wr_valid && wr_ready && wr_cnt < 128) begin
            log_row[wr_cnt]  <= int'(wr_row);
            log_col[wr_cnt]  <= int'(wr_col);
            log_data[wr_cnt] <= wr_data;
            wr_cnt           <= wr_cnt + 1;
            last_wr_cyc      <= cyc;
        end
        if (busy && done) overlap <= 1'b1;
    end

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, dp_start, wr_valid} !== 4'b0000)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, dp_start, wr_valid}); end
        checks++;
        if (row_idx !== 0 || col_idx !== 0 || wr_data !== 0)
            begin errors++; $display("FAIL reset_data: got row=%0d col=%0d data=%0d expected 0 0 0", row_idx, col_idx, wr_data); end
        rst = 1'b0;
        @(negedge clk);
        pulse_start;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dp_start !== 1'b0)
            begin errors++; $display("FAIL pre_reset_wait: got busy=%b dp_start=%b expected 1 0", busy, dp_start); end
        n = dps_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dp_start, wr_valid} !== 4'b0000 || row_idx !== 0 || col_idx !== 0)
            begin errors++; $display("FAIL async_reset: got ctrl=%b row=%0d col=%0d expected 0000 0 0", {busy, done, dp_start, wr_valid}, row_idx, col_idx); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (dps_cnt !== n || busy !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: got dp_starts=%0d busy=%b expected %0d 0", dps_cnt, busy, n); end
    endtask

    task automatic test_basic;
        int bw, bs;
        bit ok;
        bw = wr_cnt;
        bs = dps_cnt;
        pulse_start;
        wait_done(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: got done=%b expected 1", done); end
        checks++;
        if (wr_cnt - bw !== 6) begin errors++; $display("FAIL basic_writes: got %0d expected 6", wr_cnt - bw); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_row[bw+k] !== k / 3 || log_col[bw+k] !== k % 3 || log_data[bw+k] !== N'(16 * (k / 3) + k % 3))
                begin errors++; $display("FAIL basic_elem%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", k, log_row[bw+k], log_col[bw+k], log_data[bw+k], k / 3, k % 3, 16 * (k / 3) + k % 3); end
        end
        checks++;
        if (dps_cnt - bs !== 6) begin errors++; $display("FAIL basic_dp_starts: got %0d expected 6", dps_cnt - bs); end
        checks++;
        if (cyc !== last_wr_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", cyc, last_wr_cyc + 1); end
        checks++;
        if (busy !== 1'b0 || row_idx !== 1 || col_idx !== 2)
            begin errors++; $display("FAIL basic_done_state: got busy=%b row=%0d col=%0d expected 0 1 2", busy, row_idx, col_idx); end
    endtask

    task automatic test_hold_done;
        int bw, bs;
        bit ok;
        hold_mode = 1'b1;
        bw = wr_cnt;
        bs = dps_cnt;
        pulse_start;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || dp_start !== 1'b1 || row_idx !== 0 || col_idx !== 0)
            begin errors++; $display("FAIL restart_from_done: got done=%b busy=%b dp_start=%b row=%0d col=%0d expected 0 1 1 0 0", done, busy, dp_start, row_idx, col_idx); end
        wait_done(300, ok);
        checks++;
        if (!ok || wr_cnt - bw !== 6) begin errors++; $display("FAIL hold_writes: got %0d done=%b expected 6 1", wr_cnt - bw, done); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_row[bw+k] !== k / 3 || log_col[bw+k] !== k % 3 || log_data[bw+k] !== N'(16 * (k / 3) + k % 3))
                begin errors++; $display("FAIL hold_elem%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", k, log_row[bw+k], log_col[bw+k], log_data[bw+k], k / 3, k % 3, 16 * (k / 3) + k % 3); end
        end
        checks++;
        if (dps_cnt - bs !== 6) begin errors++; $display("FAIL hold_dp_starts: got %0d expected 6", dps_cnt - bs); end
        hold_mode = 1'b0;
    endtask

    task automatic test_write_stall;
        int bw, s, w;
        bit ok, found;
        bw = wr_cnt;
        found = 1'b0;
        pulse_start;
        for (int i = 0; i < 200; i++) begin
            if (wr_valid && wr_row == 0 && wr_col == 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL stall_reach: got no write of (0,1) expected one"); end
        wr_ready = 1'b0;
        s = dps_cnt;
        w = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (wr_valid !== 1'b1 || wr_data !== 1 || wr_row !== 0 || wr_col !== 1)
                begin errors++; $display("FAIL stall_hold%0d: got valid=%b (%0d,%0d)=%0d expected 1 (0,1)=1", i, wr_valid, wr_row, wr_col, wr_data); end
        end
        checks++;
        if (dps_cnt !== s || wr_cnt !== w) begin errors++; $display("FAIL stall_quiet: got dp_starts=%0d writes=%0d expected %0d %0d", dps_cnt, wr_cnt, s, w); end
        wr_ready = 1'b1;
        wait_done(300, ok);
        checks++;
        if (!ok || wr_cnt - bw !== 6) begin errors++; $display("FAIL stall_writes: got %0d done=%b expected 6 1", wr_cnt - bw, done); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_row[bw+k] !== k / 3 || log_col[bw+k] !== k % 3 || log_data[bw+k] !== N'(16 * (k / 3) + k % 3))
                begin errors++; $display("FAIL stall_elem%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", k, log_row[bw+k], log_col[bw+k], log_data[bw+k], k / 3, k % 3, 16 * (k / 3) + k % 3); end
        end
    endtask

    task automatic test_abort;
        int bw, s;
        bit ok, found;
        bw = wr_cnt;
        found = 1'b0;
        pulse_start;
        for (int i = 0; i < 300; i++) begin
            if (wr_valid && wr_row == 1 && wr_col == 0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach: got no write of (1,0) expected one"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, wr_valid} !== 3'b000 || row_idx !== 0 || col_idx !== 0)
            begin errors++; $display("FAIL abort_idle: got busy/done/valid=%b row=%0d col=%0d expected 000 0 0", {busy, done, wr_valid}, row_idx, col_idx); end
        checks++;
        if (wr_cnt - bw !== 4 || log_row[wr_cnt-1] !== 1 || log_col[wr_cnt-1] !== 0 || log_data[wr_cnt-1] !== 16)
            begin errors++; $display("FAIL abort_last_write: got count=%0d last (%0d,%0d)=%0d expected 4 (1,0)=16", wr_cnt - bw, log_row[wr_cnt-1], log_col[wr_cnt-1], log_data[wr_cnt-1]); end
        s = dps_cnt;
        repeat (5) @(negedge clk);
        checks++;
        if (dps_cnt !== s || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet: got dp_starts=%0d busy=%b expected %0d 0", dps_cnt, busy, s); end
        bw = wr_cnt;
        pulse_start;
        wait_done(300, ok);
        checks++;
        if (!ok || wr_cnt - bw !== 6) begin errors++; $display("FAIL abort_rerun_writes: got %0d done=%b expected 6 1", wr_cnt - bw, done); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_row[bw+k] !== k / 3 || log_col[bw+k] !== k % 3 || log_data[bw+k] !== N'(16 * (k / 3) + k % 3))
                begin errors++; $display("FAIL abort_rerun_elem%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", k, log_row[bw+k], log_col[bw+k], log_data[bw+k], k / 3, k % 3, 16 * (k / 3) + k % 3); end
        end
    endtask

    task automatic test_start_busy;
        int bw, bs;
        bit ok, found;
        bw = wr_cnt;
        bs = dps_cnt;
        found = 1'b0;
        pulse_start;
        for (int i = 0; i < 200; i++) begin
            if (dp_start && col_idx == 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL busy_reach: got no issue of (0,1) expected one"); end
        @(negedge clk);
        pulse_start;
        checks++;
        if (busy !== 1'b1 || dp_start !== 1'b0 || row_idx !== 0 || col_idx !== 1)
            begin errors++; $display("FAIL start_ignored: got busy=%b dp_start=%b row=%0d col=%0d expected 1 0 0 1", busy, dp_start, row_idx, col_idx); end
        wait_done(300, ok);
        checks++;
        if (!ok || wr_cnt - bw !== 6 || dps_cnt - bs !== 6)
            begin errors++; $display("FAIL busy_totals: got writes=%0d dp_starts=%0d expected 6 6", wr_cnt - bw, dps_cnt - bs); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_row[bw+k] !== k / 3 || log_col[bw+k] !== k % 3 || log_data[bw+k] !== N'(16 * (k / 3) + k % 3))
                begin errors++; $display("FAIL busy_elem%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", k, log_row[bw+k], log_col[bw+k], log_data[bw+k], k / 3, k % 3, 16 * (k / 3) + k % 3); end
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (overlap !== 1'b0) begin errors++; $display("FAIL busy_done_overlap: got %b expected 0", overlap); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold_done;
        test_write_stall;
        test_abort;
        test_start_busy;
        test_invariants;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer that computes a d1 x d3 matrix product by time-sharing one external dotproduct engine instead of instantiating d1*d3 engines.
- Walks output elements in row-major order and presents the (row, col) operand-select indices to the operand muxes.
- Pulses the engine start, waits for its done, then writes each result word into a result buffer through a ready/valid write port.
- Sits between the layer-level inference FSM (start/done) and the shared dot-product datapath.

Parameters:
- N, 32, width of each fixed-point data word (result passes through unmodified).
- d1, 5, rows of A (rows of the result).
- d3, 5, columns of B (columns of the result).
- RW, (d1>1 ? $clog2(d1) : 1), row index width (derived; not to be overridden).
- CW, (d3>1 ? $clog2(d3) : 1), column index width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a full matrix product; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle from any state.
- busy  out  1  high in ISSUE, WAIT and WRITE.
- done  out  1  level; high in DONE until next start, abort or reset.
- row_idx  out  RW  current A-row select to the operand mux.
- col_idx  out  CW  current B-column select to the operand mux.
- dp_start  out  1  one-cycle start pulse to the dot-product engine.
- dp_done  in  1  engine done (level; may remain high from the previous op).
- dp_result  in  N  engine result, valid while dp_done is high.
- wr_valid  out  1  result write request.
- wr_ready  in  1  result buffer accepts when wr_valid && wr_ready.
- wr_row  out  RW  destination row.
- wr_col  out  CW  destination column.
- wr_data  out  N  registered copy of dp_result.

Behaviour:
- Reset (async): state=IDLE, all outputs 0, indices 0, armed=0.
- IDLE: start=1 -> row_idx=col_idx=0, go to ISSUE.
- ISSUE (1 cycle): dp_start=1, armed cleared, go to WAIT.
- WAIT: sets armed on the first cycle dp_done=0. When armed && dp_done: capture dp_result into wr_data, go to WRITE.
  - dp_done held high from the previous op is never accepted before armed is set.
  - An armed dp_done on the same cycle as the low sample still requires a prior low cycle.
- WRITE: wr_valid=1 with wr_row/wr_col = current indices. wr_data, wr_row and wr_col stay stable while wr_ready=0.
- On wr_valid && wr_ready, advance indices:
  - col_idx==d3-1 -> col_idx=0, row_idx+1.
  - Last element (row d1-1, col d3-1) -> DONE. Otherwise -> ISSUE.
- DONE: done=1, indices hold. start=1 -> clear done, restart at (0,0) in ISSUE the next cycle.
- start while busy is ignored.
- abort has priority over all transitions, including a completing write. A write handshaken in the abort cycle still counts at the buffer. Controller goes to IDLE with indices=0, done=0, wr_valid=0.
- Element latency: 1 (ISSUE) + engine latency + arm cycle(s) + 1 + write stall cycles.
- Full product with zero stalls: d1*d3 elements, each min 3 cycles plus engine time.
- d1=1 or d3=1: indices of width 1 stay 0; wrap logic must still work.
- busy and done are never high together.

Test Plan:
- Reset mid-WAIT (rst pulsed asynchronously between clock edges) -> outputs 0 immediately, state IDLE, no dp_start afterwards.
- d1=2, d3=3, engine model latency 4, result = 16*row+col, wr_ready=1 -> 6 writes in order (0,0)..(1,2), data 0,1,2,16,17,18, exactly 6 dp_start pulses, done rises one cycle after last write.
- Engine holds dp_done high between ops -> no element captured before dp_done falls; writes still 6 and correct.
- wr_ready held 0 for 5 cycles on element (0,1) -> wr_valid/data/addr stable 5 cycles, no further dp_start until accepted.
- abort asserted during WRITE of element (1,0) -> IDLE next cycle, done=0, later start recomputes from (0,0).
- start pulsed while busy -> ignored; start in DONE -> done falls, new sequence begins at (0,0).
